// File: rtl/digital_clock_sync.sv
// digital_clock_sync
//   Single-clock BCD time-of-day counter (HH:MM:SS) with a RUN/STOP/SET state
//   machine, key-driven time set, 12/24 h mode and seven-segment outputs.
//   A prescaler produces a one-cycle Tick enable; all digits advance on
//   carry enables inside the one clock domain.
//
//   Optional feature: define DIGITAL_CLOCK_ALARM_EN to add alarm HH:MM registers
//   (edited in SET with Alarm_Sel=1) and the Alarm output. Without it Alarm is 0.
//
// Ports
//   CLK_50_MHZ             system clock, rising edge
//   Reset                  asynchronous, active-low
//   Time_Stop / Time_Set   mode requests (SET has priority)
//   Key_Min / Key_Hr       active-high keys, one increment per rising edge in SET
//   Alarm_Sel              SET: 1 = keys edit the alarm (alarm build only)
//   Sec_Ones..Hr_Tens      BCD digits
//   PM                     12 h PM flag (0 in 24 h mode)
//   Tick                   one-cycle 1 Hz enable, RUN only
//   Alarm                  alarm active
//   Hex0..Hex5             active-low seven-segment (index 0 = seg a) of the digits
module digital_clock_sync #(
  parameter int CLK_HZ  = 50_000_000,
  parameter bit HOUR_24 = 1'b1,
  parameter int PRE_W   = 26
) (
  input  logic       CLK_50_MHZ,
  input  logic       Reset,
  input  logic       Time_Stop,
  input  logic       Time_Set,
  input  logic       Key_Min,
  input  logic       Key_Hr,
  input  logic       Alarm_Sel,
  output logic [3:0] Sec_Ones,
  output logic [3:0] Sec_Tens,
  output logic [3:0] Min_Ones,
  output logic [3:0] Min_Tens,
  output logic [3:0] Hr_Ones,
  output logic [3:0] Hr_Tens,
  output logic       PM,
  output logic       Tick,
  output logic       Alarm,
  output logic [0:6] Hex0,
  output logic [0:6] Hex1,
  output logic [0:6] Hex2,
  output logic [0:6] Hex3,
  output logic [0:6] Hex4,
  output logic [0:6] Hex5
);

  typedef struct packed { logic [3:0] tens; logic [3:0] ones; } bcd2_t;
  typedef struct packed { logic [3:0] tens; logic [3:0] ones; logic pm; } hour_t;
  typedef enum logic [1:0] {ST_RUN, ST_STOP, ST_SET} state_t;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
  // 24 h resets to 00, 12 h resets to 12 AM
  localparam logic [8:0]       HR_RST  = HOUR_24 ? 9'h000 : {4'd1, 4'd2, 1'b0};

  // 00..59 BCD increment with wrap
  function automatic bcd2_t bcd60_inc(bcd2_t v);
    bcd2_t n;
    n = v;
    if (v.ones == 4'd9) begin
      n.ones = 4'd0;
      n.tens = (v.tens == 4'd5) ? 4'd0 : v.tens + 4'd1;
    end else begin
      n.ones = v.ones + 4'd1;
    end
    return n;
  endfunction

  // Hour increment: 23->00 in 24 h; 12->01 and 11->12 (PM toggles) in 12 h
  function automatic hour_t hour_inc(hour_t h);
    hour_t n;
    n = h;
    if (HOUR_24) begin
      if (h.tens == 4'd2 && h.ones == 4'd3) begin
        n.tens = 4'd0;
        n.ones = 4'd0;
      end else if (h.ones == 4'd9) begin
        n.tens = h.tens + 4'd1;
        n.ones = 4'd0;
      end else begin
        n.ones = h.ones + 4'd1;
      end
    end else begin
      if (h.tens == 4'd1 && h.ones == 4'd2) begin
        n.tens = 4'd0;
        n.ones = 4'd1;
      end else if (h.tens == 4'd1 && h.ones == 4'd1) begin
        n.ones = 4'd2;
        n.pm   = ~h.pm;
      end else if (h.ones == 4'd9) begin
        n.tens = 4'd1;
        n.ones = 4'd0;
      end else begin
        n.ones = h.ones + 4'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [0:6] binary2seven(logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_t           r_state, w_state_n;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_kmin_sync, r_khr_sync;
  logic             r_kmin_d, r_khr_d;
  logic             w_min_edge, w_hr_edge, w_tick, w_edit_alarm;
  bcd2_t            r_sec, r_min, w_sec_n, w_min_n;
  hour_t            r_hr, w_hr_n;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK_50_MHZ or negedge Reset) begin
    if (!Reset) r_state <= ST_RUN;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_RUN:  if (Time_Set) w_state_n = ST_SET; else if (Time_Stop)  w_state_n = ST_STOP;
      ST_STOP: if (Time_Set) w_state_n = ST_SET; else if (!Time_Stop) w_state_n = ST_RUN;
      ST_SET:  if (!Time_Set) w_state_n = Time_Stop ? ST_STOP : ST_RUN;
      default: w_state_n = ST_RUN;
    endcase
  end

  // ---------------- prescaler ----------------
  // STOP keeps the phase; SET zeroes it so the first second after SET is full.
  always_ff @(posedge CLK_50_MHZ or negedge Reset) begin
    if (!Reset) begin
      r_pre <= '0;
    end else begin
      case (r_state)
        ST_RUN:  r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
        ST_SET:  r_pre <= '0;
        default: r_pre <= r_pre;
      endcase
    end
  end

  assign w_tick = (r_state == ST_RUN) && (r_pre == PRE_MAX);
  assign Tick   = w_tick;

  // ---------------- keys: 2-flop sync + edge register ----------------
  always_ff @(posedge CLK_50_MHZ or negedge Reset) begin
    if (!Reset) begin
      r_kmin_sync <= '0;
      r_khr_sync  <= '0;
      r_kmin_d    <= 1'b0;
      r_khr_d     <= 1'b0;
    end else begin
      r_kmin_sync <= {r_kmin_sync[0], Key_Min};
      r_khr_sync  <= {r_khr_sync[0], Key_Hr};
      r_kmin_d    <= r_kmin_sync[1];
      r_khr_d     <= r_khr_sync[1];
    end
  end

  assign w_min_edge = r_kmin_sync[1] & ~r_kmin_d;
  assign w_hr_edge  = r_khr_sync[1] & ~r_khr_d;

  // ---------------- time digits ----------------
  // Tick only occurs in RUN, so it can never collide with a SET edit.
  always_comb begin
    w_sec_n = r_sec;
    w_min_n = r_min;
    w_hr_n  = r_hr;
    if (w_tick) begin
      w_sec_n = bcd60_inc(r_sec);
      if (r_sec == 8'h59) begin
        w_min_n = bcd60_inc(r_min);
        if (r_min == 8'h59) w_hr_n = hour_inc(r_hr);
      end
    end else if (r_state == ST_SET && !w_edit_alarm) begin
      if (w_min_edge) begin
        w_min_n = bcd60_inc(r_min);
        w_sec_n = 8'h00;
      end
      if (w_hr_edge) w_hr_n = hour_inc(r_hr);
    end
  end

  always_ff @(posedge CLK_50_MHZ or negedge Reset) begin
    if (!Reset) begin
      r_sec <= 8'h00;
      r_min <= 8'h00;
      r_hr  <= hour_t'(HR_RST);
    end else begin
      r_sec <= w_sec_n;
      r_min <= w_min_n;
      r_hr  <= w_hr_n;
    end
  end

  // ---------------- alarm ----------------
`ifdef DIGITAL_CLOCK_ALARM_EN
  bcd2_t r_amin;
  hour_t r_ahr;
  logic  r_alarm, r_tick_d;

  assign w_edit_alarm = (r_state == ST_SET) && Alarm_Sel;

  // r_tick_d marks the first cycle the digits show a freshly ticked value, so
  // a match fires once per HH:MM:00 and a dismissed alarm stays dismissed.
  always_ff @(posedge CLK_50_MHZ or negedge Reset) begin
    if (!Reset) begin
      r_amin   <= 8'h00;
      r_ahr    <= hour_t'(HR_RST);
      r_alarm  <= 1'b0;
      r_tick_d <= 1'b0;
    end else begin
      r_tick_d <= w_tick;
      if (w_edit_alarm) begin
        if (w_min_edge) r_amin <= bcd60_inc(r_amin);
        if (w_hr_edge)  r_ahr  <= hour_inc(r_ahr);
      end
      if (r_state == ST_SET ||
          (r_state == ST_RUN && (w_min_edge || w_hr_edge)) ||
          (w_tick && r_sec == 8'h59))
        r_alarm <= 1'b0;
      else if (r_state == ST_RUN && r_tick_d && r_sec == 8'h00 &&
               r_min == r_amin && r_hr == r_ahr)
        r_alarm <= 1'b1;
    end
  end

  assign Alarm = r_alarm;
`else
  logic w_unused_alarm_sel;
  assign w_unused_alarm_sel = Alarm_Sel;
  assign w_edit_alarm       = 1'b0;
  assign Alarm              = 1'b0;
`endif

  // ---------------- outputs ----------------
  assign Sec_Ones = r_sec.ones;
  assign Sec_Tens = r_sec.tens;
  assign Min_Ones = r_min.ones;
  assign Min_Tens = r_min.tens;
  assign Hr_Ones  = r_hr.ones;
  assign Hr_Tens  = r_hr.tens;
  assign PM       = HOUR_24 ? 1'b0 : r_hr.pm;

  assign Hex0 = binary2seven(r_sec.ones);
  assign Hex1 = binary2seven(r_sec.tens);
  assign Hex2 = binary2seven(r_min.ones);
  assign Hex3 = binary2seven(r_min.tens);
  assign Hex4 = binary2seven(r_hr.ones);
  assign Hex5 = binary2seven(r_hr.tens);

endmodule

// File: tb/tb_digital_clock_sync.sv
// Scoreboard bench for digital_clock_sync: a 24 h and a 12 h instance share
// stimulus; a reference model keeps time as seconds-of-day and pushes the
// expected outputs each cycle, and a negedge monitor pops and compares.
module tb_digital_clock_sync;
  localparam int HZ = 10;
`ifdef DIGITAL_CLOCK_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic t_stop = 1'b0, t_set = 1'b0, k_min = 1'b0, k_hr = 1'b0, a_sel = 1'b0;

  logic [3:0] so24, st24, mo24, mt24, ho24, ht24;
  logic [3:0] so12, st12, mo12, mt12, ho12, ht12;
  logic       pm24, tick24, al24, pm12, tick12, al12;
  logic [0:6] h0a, h1a, h2a, h3a, h4a, h5a;
  logic [0:6] h0b, h1b, h2b, h3b, h4b, h5b;

  always #5 clk = ~clk;

  digital_clock_sync #(.CLK_HZ(HZ), .HOUR_24(1'b1), .PRE_W(4)) u_dut24 (
    .CLK_50_MHZ(clk), .Reset(rst_n), .Time_Stop(t_stop), .Time_Set(t_set),
    .Key_Min(k_min), .Key_Hr(k_hr), .Alarm_Sel(a_sel),
    .Sec_Ones(so24), .Sec_Tens(st24), .Min_Ones(mo24), .Min_Tens(mt24),
    .Hr_Ones(ho24), .Hr_Tens(ht24), .PM(pm24), .Tick(tick24), .Alarm(al24),
    .Hex0(h0a), .Hex1(h1a), .Hex2(h2a), .Hex3(h3a), .Hex4(h4a), .Hex5(h5a));

  digital_clock_sync #(.CLK_HZ(HZ), .HOUR_24(1'b0), .PRE_W(4)) u_dut12 (
    .CLK_50_MHZ(clk), .Reset(rst_n), .Time_Stop(t_stop), .Time_Set(t_set),
    .Key_Min(k_min), .Key_Hr(k_hr), .Alarm_Sel(a_sel),
    .Sec_Ones(so12), .Sec_Tens(st12), .Min_Ones(mo12), .Min_Tens(mt12),
    .Hr_Ones(ho12), .Hr_Tens(ht12), .PM(pm12), .Tick(tick12), .Alarm(al12),
    .Hex0(h0b), .Hex1(h1b), .Hex2(h2b), .Hex3(h3b), .Hex4(h4b), .Hex5(h5b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s wait bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int sec; bit tick; bit alarm; } exp_t;
  exp_t q[$];

  int m_st;      // 0 RUN, 1 STOP, 2 SET
  int m_pre, m_sec, m_amin;
  bit m_alarm, m_tick_d;
  bit kmin_h[3], khr_h[3];  // key samples from 1, 2, 3 edges ago

  task automatic model_reset();
    m_st = 0; m_pre = 0; m_sec = 0; m_amin = 0; m_alarm = 0; m_tick_d = 0;
    for (int i = 0; i < 3; i++) begin kmin_h[i] = 0; khr_h[i] = 0; end
  endtask

  task automatic step();
    bit tk, emin, ehr;
    tk   = (m_st == 0) && (m_pre == HZ - 1);
    emin = kmin_h[1] && !kmin_h[2];
    ehr  = khr_h[1] && !khr_h[2];
    if (ALARM) begin
      if (m_st == 2 || (m_st == 0 && (emin || ehr)) || (tk && m_sec % 60 == 59))
        m_alarm = 0;
      else if (m_st == 0 && m_tick_d && m_sec % 60 == 0 && m_sec / 60 == m_amin)
        m_alarm = 1;
      m_tick_d = tk;
    end
    if (tk) m_sec = (m_sec + 1) % 86400;
    else if (m_st == 2) begin
      if (ALARM && a_sel) begin
        if (emin) m_amin = (m_amin / 60) * 60 + (m_amin % 60 + 1) % 60;
        if (ehr)  m_amin = ((m_amin / 60 + 1) % 24) * 60 + m_amin % 60;
      end else begin
        if (emin) m_sec = (m_sec / 3600) * 3600 + (((m_sec / 60) % 60 + 1) % 60) * 60;
        if (ehr)  m_sec = ((m_sec / 3600 + 1) % 24) * 3600 + m_sec % 3600;
      end
    end
    if (m_st == 0) m_pre = (m_pre == HZ - 1) ? 0 : m_pre + 1;
    else if (m_st == 2) m_pre = 0;
    case (m_st)
      0: if (t_set) m_st = 2; else if (t_stop) m_st = 1;
      1: if (t_set) m_st = 2; else if (!t_stop) m_st = 0;
      default: if (!t_set) m_st = t_stop ? 1 : 0;
    endcase
    kmin_h[2] = kmin_h[1]; kmin_h[1] = kmin_h[0]; kmin_h[0] = k_min;
    khr_h[2]  = khr_h[1];  khr_h[1]  = khr_h[0];  khr_h[0]  = k_hr;
    q.push_back('{m_sec, (m_st == 0) && (m_pre == HZ - 1), m_alarm});
  endtask

  function automatic logic [23:0] bcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // ---------------- monitor ----------------
  exp_t me;
  int   mh, mm, ms, mh12;
  logic [23:0] md;
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      me = q.pop_front();
      mh = me.sec / 3600; mm = (me.sec / 60) % 60; ms = me.sec % 60;
      mh12 = (mh % 12 == 0) ? 12 : mh % 12;
      md = bcd(mh, mm, ms);
      check("digits24", {ht24, ho24, mt24, mo24, st24, so24}, md);
      check("pm24", pm24, 0);
      check("tick24", tick24, me.tick);
      check("alarm24", al24, me.alarm);
      check("digits12", {pm12, ht12, ho12, mt12, mo12, st12, so12},
            {(mh >= 12), bcd(mh12, mm, ms)});
      check("tick12", tick12, me.tick);
      check("alarm12", al12, me.alarm);
      check("hex24", {h5a, h4a, h3a, h2a, h1a, h0a},
            {SEG[md[23:20]], SEG[md[19:16]], SEG[md[15:12]],
             SEG[md[11:8]], SEG[md[7:4]], SEG[md[3:0]]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      step();
      #1;
    end
  endtask

  task automatic press(input bit hr, input int hi, input int lo);
    if (hr) k_hr = 1'b1; else k_min = 1'b1;
    cyc(hi);
    k_hr = 1'b0; k_min = 1'b0;
    cyc(lo);
  endtask

  task automatic presses(input bit hr, input int n);
    for (int i = 0; i < n; i++) press(hr, $urandom_range(1, 3), $urandom_range(1, 3));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    t_stop = 0; t_set = 0; k_min = 0; k_hr = 0; a_sel = 0;
    #1;
    check("rst_digits24", {ht24, ho24, mt24, mo24, st24, so24}, 24'h000000);
    check("rst_tick24", tick24, 0);
    check("rst_alarm24", al24, 0);
    check("rst_digits12", {pm12, ht12, ho12, mt12, mo12, st12, so12}, {1'b0, 24'h120000});
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  bit seen;
  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset in the middle of a second, then first tick
    cyc(27);
    do_reset();
    cyc(25);

    // 24 h rollover: set 23:59:00 and run past midnight
    t_set = 1; cyc(2);
    presses(1, 23); presses(0, 59);
    t_set = 0; cyc(600 + 15);

    // 12 h: 11:59 -> 12:00 PM, then 12:59 -> 01:00 PM
    t_set = 1; cyc(2);
    presses(1, 11); presses(0, 59);
    t_set = 0; cyc(605);
    t_set = 1; cyc(2);
    presses(0, 59);
    t_set = 0; cyc(605);

    // STOP at prescaler 6 for 50 cycles
    begin
      int i;
      for (i = 0; i < 30 && m_pre != 6; i++) cyc(1);
      if (m_pre != 6) timeout("reach_pre6");
    end
    t_stop = 1; cyc(50);
    t_stop = 0; cyc(25);

    // 61 minute presses wrap to +1; long hold counts once
    t_set = 1; cyc(2);
    presses(0, 61);
    press(0, 20, 4);
    press(1, 20, 4);
    t_set = 0; cyc(25);

    // randomized mode/key activity
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) t_set = ~t_set;
      if ($urandom_range(0, 29) == 0) t_stop = ~t_stop;
      if ($urandom_range(0, 3) == 0) k_min = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) k_hr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) a_sel = 1'($urandom_range(0, 1));
      cyc(1);
    end
    t_set = 0; t_stop = 0; k_min = 0; k_hr = 0; a_sel = 0;
    cyc(10);

`ifdef DIGITAL_CLOCK_ALARM_EN
    // alarm 00:01, run from 00:00:00, dismiss with Key_Hr
    do_reset();
    t_set = 1; a_sel = 1; cyc(2);
    press(0, 2, 3);
    t_set = 0; a_sel = 0; cyc(2);
    begin
      int i;
      for (i = 0; i < 800 && !m_alarm; i++) cyc(1);
      if (!m_alarm) timeout("alarm_wait");
    end
    cyc(3);
    seen = al24;
    check("alarm_rise", seen, 1);
    cyc(20);
    press(1, 2, 5);
    check("alarm_dismiss", al24, 0);
`else
    seen = 0;
`endif

    cyc(2);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end
endmodule
